conv3x3_relu_pe: RTL



---
 rtl/conv3x3_relu_pe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_relu_pe.sv
// 3x3 convolution processing element: runtime-loaded signed kernel and bias, ReLU,
// right shift and saturation. Border windows are dropped; latency is 4 cycles per kept beat.
module conv3x3_relu_pe #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int IMG_WIDTH    = 28,
    parameter int IMG_HEIGHT   = 28,
    parameter int ACC_WIDTH    = 20,
    parameter int OUT_SHIFT    = 0,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wload_start,
    input  logic                    wload_valid,
    input  logic [WEIGHT_WIDTH-1:0] wload_data,
    output logic                    weights_ready,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   w00,
    input  logic [DATA_WIDTH-1:0]   w01,
    input  logic [DATA_WIDTH-1:0]   w02,
    input  logic [DATA_WIDTH-1:0]   w10,
    input  logic [DATA_WIDTH-1:0]   w11,
    input  logic [DATA_WIDTH-1:0]   w12,
    input  logic [DATA_WIDTH-1:0]   w20,
    input  logic [DATA_WIDTH-1:0]   w21,
    input  logic [DATA_WIDTH-1:0]   w22,
    output logic                    valid_out,
    output logic [OUT_WIDTH-1:0]    pixel_out,
    output logic                    frame_done
);
    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH + 1;
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << OUT_WIDTH) - 1);
    localparam logic [OUT_WIDTH-1:0] PIX_MAX = {OUT_WIDTH{1'b1}};

    typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                          state_q;
    logic [3:0]                      idx_q;
    logic signed [WEIGHT_WIDTH-1:0]  kern_q [9];
    logic signed [ACC_WIDTH-1:0]     bias_q;
    logic                            weights_ready_q;
    logic [COL_W-1:0]                col_q;
    logic [ROW_W-1:0]                row_q;

    logic [DATA_WIDTH-1:0]           pix_s [9];
    logic                            keep_s;
    logic                            last_s;

    logic signed [PROD_W-1:0]        prod_d [9];
    logic signed [PROD_W-1:0]        prod_q [9];
    logic signed [ACC_WIDTH-1:0]     rsum_d [3];
    logic signed [ACC_WIDTH-1:0]     rsum_q [3];
    logic signed [ACC_WIDTH-1:0]     bias_s1_q, bias_s2_q;
    logic signed [ACC_WIDTH-1:0]     acc_d, acc_q, shift_s;
    logic                            v1_q, v2_q, v3_q, l1_q, l2_q, l3_q;
    logic [OUT_WIDTH-1:0]            pix_d;
    logic                            valid_out_q, frame_done_q;
    logic [OUT_WIDTH-1:0]            pixel_out_q;

    assign pix_s[0] = w00;
    assign pix_s[1] = w01;
    assign pix_s[2] = w02;
    assign pix_s[3] = w10;
    assign pix_s[4] = w11;
    assign pix_s[5] = w12;
    assign pix_s[6] = w20;
    assign pix_s[7] = w21;
    assign pix_s[8] = w22;

    // A beat coinciding with a reload request is dropped along with the old frame position
    assign keep_s = valid_in && (state_q == ST_RUN) && !wload_start &&
                    (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign last_s = (row_q == ROW_W'(IMG_HEIGHT - 1)) && (col_q == COL_W'(IMG_WIDTH - 1));

    assign weights_ready = weights_ready_q;
    assign valid_out     = valid_out_q;
    assign pixel_out     = pixel_out_q;
    assign frame_done    = frame_done_q;

    // Load/run control, coefficient storage and frame position counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_LOAD;
            idx_q           <= 4'd0;
            bias_q          <= {ACC_WIDTH{1'b0}};
            weights_ready_q <= 1'b0;
            col_q           <= {COL_W{1'b0}};
            row_q           <= {ROW_W{1'b0}};
            for (int i = 0; i < 9; i++) kern_q[i] <= {WEIGHT_WIDTH{1'b0}};
        end else if (wload_start) begin
            state_q         <= ST_LOAD;
            idx_q           <= 4'd0;
            weights_ready_q <= 1'b0;
            col_q           <= {COL_W{1'b0}};
            row_q           <= {ROW_W{1'b0}};
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (wload_valid) begin
                        if (idx_q == 4'd9) begin
                            bias_q          <= ACC_WIDTH'($signed(wload_data));
                            idx_q           <= 4'd0;
                            state_q         <= ST_RUN;
                            weights_ready_q <= 1'b1;
                        end else begin
                            kern_q[idx_q] <= $signed(wload_data);
                            idx_q         <= idx_q + 4'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (valid_in) begin
                        if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                            col_q <= {COL_W{1'b0}};
                            if (row_q == ROW_W'(IMG_HEIGHT - 1)) row_q <= {ROW_W{1'b0}};
                            else                                 row_q <= row_q + ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                default: begin
                    state_q         <= ST_LOAD;
                    idx_q           <= 4'd0;
                    weights_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Multiplier array and adder tree feeding the pipeline registers
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = PROD_W'($signed({1'b0, pix_s[i]})) * PROD_W'(kern_q[i]);
        end
        for (int r = 0; r < 3; r++) begin
            rsum_d[r] = ACC_WIDTH'(prod_q[3*r]) + ACC_WIDTH'(prod_q[3*r+1]) +
                        ACC_WIDTH'(prod_q[3*r+2]);
        end
        acc_d = rsum_q[0] + rsum_q[1] + rsum_q[2] + bias_s2_q;
    end

    // ReLU, arithmetic shift and saturation of the accumulated sum
    always_comb begin
        shift_s = acc_q >>> OUT_SHIFT;
        if (acc_q[ACC_WIDTH-1]) begin
            pix_d = {OUT_WIDTH{1'b0}};
        end else if (shift_s > SAT_MAX) begin
            pix_d = PIX_MAX;
        end else begin
            pix_d = shift_s[OUT_WIDTH-1:0];
        end
    end

    // Four-stage datapath; bias travels with each beat so a reload never corrupts in-flight work
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= {PROD_W{1'b0}};
            for (int r = 0; r < 3; r++) rsum_q[r] <= {ACC_WIDTH{1'b0}};
            bias_s1_q    <= {ACC_WIDTH{1'b0}};
            bias_s2_q    <= {ACC_WIDTH{1'b0}};
            acc_q        <= {ACC_WIDTH{1'b0}};
            {v1_q, v2_q, v3_q, l1_q, l2_q, l3_q} <= 6'b000000;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pixel_out_q  <= {OUT_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            for (int r = 0; r < 3; r++) rsum_q[r] <= rsum_d[r];
            bias_s1_q    <= bias_q;
            bias_s2_q    <= bias_s1_q;
            acc_q        <= acc_d;
            v1_q         <= keep_s;
            l1_q         <= keep_s && last_s;
            v2_q         <= v1_q;
            l2_q         <= l1_q;
            v3_q         <= v2_q;
            l3_q         <= l2_q;
            valid_out_q  <= v3_q;
            frame_done_q <= v3_q && l3_q;
            if (v3_q) pixel_out_q <= pix_d;
            else      pixel_out_q <= pixel_out_q;
        end
    end
endmodule
